// File: rtl/seq_scan_controller.sv
// Scan controller: captures a word and target pattern, streams the word MSB-first
// through a PAT_W-bit detection window and reports match count and positions.
module seq_scan_controller #(
    parameter int WORD_W = 16,
    parameter int PAT_W  = 3,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              overlap,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_count,
    output logic [WORD_W-1:0] match_pos,
    output logic              ser_x,
    output logic              ser_y
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t            state, state_next;
    logic [WORD_W-1:0] cap_word, shreg, pos_oh;
    logic [PAT_W-1:0]  cap_pat, window, window_next;
    logic              cap_ovl;
    logic [FW-1:0]     fill, fill_next;
    logic              match;

    function automatic logic [FW-1:0] sat_fill(input logic [FW-1:0] f);
        return (f >= FILL_FULL) ? FILL_FULL : f + FW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        case (state)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD:  state_next = S_SHIFT;
            S_SHIFT: if (pos_oh[0]) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Serial bit and the window/fill values that the current edge would commit
    always_comb begin
        ser_x       = (state == S_SHIFT) ? shreg[WORD_W-1] : 1'b0;
        window_next = {window[PAT_W-2:0], ser_x};
        fill_next   = sat_fill(fill);
        match       = (state == S_SHIFT) && (fill_next == FILL_FULL) &&
                      (window_next == cap_pat);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            window      <= '0;
            fill        <= '0;
            match_count <= '0;
            match_pos   <= '0;
            ser_y       <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    window      <= '0;
                    fill        <= '0;
                    match_count <= '0;
                    match_pos   <= '0;
                    ser_y       <= 1'b0;
                end
                S_SHIFT: begin
                    window <= window_next;
                    fill   <= (match && !cap_ovl) ? '0 : fill_next;
                    ser_y  <= match;
                    if (match) begin
                        match_count <= match_count + CNT_W'(1);
                        match_pos   <= match_pos | pos_oh;
                    end
                end
                default: ser_y <= 1'b0;
            endcase
        end
    end

    // pos_oh tracks the word bit being shifted; its LSB marks the final SHIFT cycle
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                if (start) begin
                    cap_word <= word;
                    cap_pat  <= pattern;
                    cap_ovl  <= overlap;
                end
            end
            S_LOAD: begin
                shreg  <= cap_word;
                pos_oh <= {1'b1, {(WORD_W-1){1'b0}}};
            end
            S_SHIFT: begin
                shreg  <= shreg << 1;
                pos_oh <= pos_oh >> 1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_scan_controller.sv
// Directed and randomized scans of seq_scan_controller checked against a
// substring-matching reference model.
module tb_seq_scan_controller;

    localparam int WORD_W = 16;
    localparam int PAT_W  = 3;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              reset, start, overlap;
    logic [WORD_W-1:0] word;
    logic [PAT_W-1:0]  pattern;
    logic              busy, done, ser_x, ser_y;
    logic [CNT_W-1:0]  match_count;
    logic [WORD_W-1:0] match_pos;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_scan_controller #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .word(word), .pattern(pattern),
        .overlap(overlap), .busy(busy), .done(done), .match_count(match_count),
        .match_pos(match_pos), .ser_x(ser_x), .ser_y(ser_y)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A match completes at bit k when the PAT_W bits ending there equal the
    // pattern; without overlap the previous match must be at least PAT_W bits back.
    task automatic model(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p,
                         input logic o, output logic [WORD_W-1:0] mk,
                         output int cnt, output logic [WORD_W-1:0] pos);
        int last, seg;
        last = -100;
        mk = '0; pos = '0; cnt = 0;
        for (int k = 0; k < WORD_W; k++) begin
            if (k >= PAT_W - 1) begin
                seg = (int'(w) >> (WORD_W - 1 - k)) & ((1 << PAT_W) - 1);
                if (seg == int'(p) && (o || (k - last) >= PAT_W)) begin
                    mk[k] = 1'b1;
                    pos[WORD_W-1-k] = 1'b1;
                    cnt++;
                    last = k;
                end
            end
        end
    endtask

    // Entered in an IDLE cycle; returns in the IDLE cycle after DONE.
    task automatic scan(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p,
                        input logic o, input int g1, input int g2, input bit hold,
                        input string tag);
        logic [WORD_W-1:0] mk, pos;
        int cnt, k;
        model(w, p, o, mk, cnt, pos);
        word = w; pattern = p; overlap = o; start = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            step();
            word    = WORD_W'($urandom);
            pattern = PAT_W'($urandom);
            overlap = 1'($urandom);
            start   = (c == g1 || c == g2 || (hold && c >= 16)) ? 1'b1 : 1'b0;
            if (c == 1) begin
                chk($sformatf("%s.load.busy", tag), busy, 1);
                chk($sformatf("%s.load.ser_y", tag), ser_y, 0);
            end else if (c <= 17) begin
                k = c - 2;
                chk($sformatf("%s.k%0d.ser_x", tag, k), ser_x, w[WORD_W-1-k]);
                chk($sformatf("%s.k%0d.ser_y", tag, k), ser_y, (k > 0) ? mk[k-1] : 1'b0);
                chk($sformatf("%s.k%0d.done", tag, k), done, 0);
            end else if (c == 18) begin
                chk($sformatf("%s.done", tag), done, 1);
                chk($sformatf("%s.done.busy", tag), busy, 1);
                chk($sformatf("%s.done.ser_y", tag), ser_y, mk[WORD_W-1]);
                chk($sformatf("%s.count", tag), match_count, cnt);
                chk($sformatf("%s.pos", tag), match_pos, pos);
            end else begin
                chk($sformatf("%s.idle.done", tag), done, 0);
                chk($sformatf("%s.idle.busy", tag), busy, 0);
                chk($sformatf("%s.idle.ser_y", tag), ser_y, 0);
                chk($sformatf("%s.hold.count", tag), match_count, cnt);
                chk($sformatf("%s.hold.pos", tag), match_pos, pos);
            end
        end
    endtask

    task automatic scan_const(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p,
                              input logic o, input int ecnt, input logic [WORD_W-1:0] epos,
                              input string tag);
        scan(w, p, o, 0, 0, 1'b0, tag);
        chk({tag, ".const_count"}, match_count, ecnt);
        chk({tag, ".const_pos"}, match_pos, epos);
    endtask

    initial begin
        logic [WORD_W-1:0] mk, pos;
        int cnt;
        bit seen_done;

        reset = 1'b1; start = 1'b0; word = '0; pattern = '0; overlap = 1'b0;
        repeat (3) step();
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.count", match_count, 0);
        chk("rst.pos", match_pos, 0);
        chk("rst.ser_x", ser_x, 0);
        chk("rst.ser_y", ser_y, 0);
        reset = 1'b0;
        step();
        chk("idle.busy", busy, 0);

        scan_const(16'h5000, 3'b010, 1'b1, 2, 16'h2800, "w5000_ov");
        scan_const(16'h5000, 3'b010, 1'b0, 1, 16'h2000, "w5000_no");
        scan_const(16'h5555, 3'b010, 1'b1, 7, 16'h2AAA, "w5555_ov");
        scan_const(16'h5555, 3'b010, 1'b0, 4, 16'h2222, "w5555_no");
        scan_const(16'hFFFF, 3'b010, 1'b1, 0, 16'h0000, "wFFFF");
        scan_const(16'hF000, 3'b111, 1'b1, 2, 16'h3000, "wF000_111");

        // Start pulses with changed inputs at cycles 3 and 10 are ignored
        scan(16'h5000, 3'b010, 1'b1, 3, 10, 1'b0, "glitch");
        chk("glitch.const_count", match_count, 2);
        chk("glitch.const_pos", match_pos, 16'h2800);

        // start held through DONE into IDLE launches the next scan immediately
        scan(16'h5555, 3'b010, 1'b0, 0, 0, 1'b1, "held");
        scan(16'hF000, 3'b111, 1'b1, 0, 0, 1'b0, "after_held");
        chk("after_held.const_count", match_count, 2);

        // Reset during SHIFT cycle k=6 aborts the scan
        model(16'h5555, 3'b010, 1'b1, mk, cnt, pos);
        word = 16'h5555; pattern = 3'b010; overlap = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        chk("abort.pre_count", match_count, $countones(mk[5:0]));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.count", match_count, 0);
        chk("abort.pos", match_pos, 0);
        chk("abort.ser_y", ser_y, 0);
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done || busy) seen_done = 1'b1;
        end
        chk("abort.no_done", seen_done, 0);
        scan_const(16'h5000, 3'b010, 1'b1, 2, 16'h2800, "fresh");

        for (int r = 0; r < 8; r++)
            scan(WORD_W'($urandom), PAT_W'($urandom), 1'($urandom), 0, 0, 1'b0,
                 $sformatf("rand%0d", r));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
